// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Shares the single-port program memory between fetch, the
//                MEM-stage data port and the program loader. Optional fetch
//                starvation guard enabled by defining PMEM_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int WORD_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_load_mode,
    input  logic                  in_fetch_req,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_gnt,
    output logic                  out_fetch_rvalid,
    input  logic                  in_data_req,
    input  logic                  in_data_we,
    input  logic [ADDR_WIDTH-1:0] in_data_addr,
    input  logic [WORD_WIDTH-1:0] in_data_wdata,
    output logic                  out_data_gnt,
    output logic                  out_data_rvalid,
    input  logic                  in_load_req,
    input  logic [ADDR_WIDTH-1:0] in_load_addr,
    input  logic [WORD_WIDTH-1:0] in_load_wdata,
    output logic                  out_load_gnt,
    output logic                  out_load_busy,
    output logic [WORD_WIDTH-1:0] out_rdata,
    output logic [ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [WORD_WIDTH-1:0] out_pmem_wdata,
    output logic                  out_pmem_we,
    input  logic [WORD_WIDTH-1:0] in_pmem_rdata
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_fetch_gnt;
    logic   w_data_gnt;
    logic   w_load_gnt;
    logic   w_promote;
    logic   r_fetch_rvalid;
    logic   r_data_rvalid;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** STARVE_WIDTH) - 1) begin : g_bad_starve_cfg
            $error("pmem_arbiter: STARVE_WIDTH cannot hold STARVE_LIMIT, or STARVE_LIMIT < 1");
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fetch_gnt  = 1'b0;
        w_data_gnt   = 1'b0;
        w_load_gnt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (in_load_mode) begin
                    w_state_next = ST_LOAD;
                end
                if (in_fetch_req && (w_promote || !in_data_req)) begin
                    w_fetch_gnt = 1'b1;
                end else if (in_data_req) begin
                    w_data_gnt = 1'b1;
                end
            end
            ST_LOAD: begin
                w_load_gnt = in_load_req;
                if (!in_load_mode) begin
                    w_state_next = ST_RELEASE;
                end
            end
            // One dead cycle for write-to-read turnaround before the core resumes.
            ST_RELEASE: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

`ifdef PMEM_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_WIDTH-1:0] c_STARVE_LIMIT = STARVE_WIDTH'(STARVE_LIMIT);

    logic [STARVE_WIDTH-1:0] r_starve;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (r_state != ST_RUN || !in_fetch_req || w_fetch_gnt) begin
            r_starve <= '0;
        end else if (r_starve != c_STARVE_LIMIT) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_promote = (r_starve == c_STARVE_LIMIT);
`else
    assign w_promote = 1'b0;
`endif

    always_comb begin
        out_pmem_addr  = in_fetch_addr;
        out_pmem_wdata = in_data_wdata;
        out_pmem_we    = 1'b0;
        if (w_load_gnt) begin
            out_pmem_addr  = in_load_addr;
            out_pmem_wdata = in_load_wdata;
            out_pmem_we    = 1'b1;
        end else if (w_data_gnt) begin
            out_pmem_addr  = in_data_addr;
            out_pmem_wdata = in_data_wdata;
            out_pmem_we    = in_data_we;
        end
    end

    // Read data arrives one cycle after the grant, matching the memory's registered read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
        end else begin
            r_fetch_rvalid <= w_fetch_gnt;
            r_data_rvalid  <= w_data_gnt & ~in_data_we;
        end
    end

    assign out_fetch_gnt    = w_fetch_gnt;
    assign out_data_gnt     = w_data_gnt;
    assign out_load_gnt     = w_load_gnt;
    assign out_fetch_rvalid = r_fetch_rvalid;
    assign out_data_rvalid  = r_data_rvalid;
    assign out_load_busy    = (r_state != ST_RUN);
    assign out_rdata        = in_pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_arbiter
//  Description : Directed scoreboard bench for pmem_arbiter with a behavioural
//                synchronous-read program memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

`ifdef PMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        load_mode;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic        data_req;
    logic        data_we;
    logic [11:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic        load_req;
    logic [11:0] load_addr;
    logic [15:0] load_wdata;
    logic        load_gnt;
    logic        load_busy;
    logic [15:0] rdata;
    logic [11:0] pmem_addr;
    logic [15:0] pmem_wdata;
    logic        pmem_we;
    logic [15:0] pmem_rdata;

    pmem_arbiter #(
        .ADDR_WIDTH  (12),
        .WORD_WIDTH  (16),
        .STARVE_LIMIT(4),
        .STARVE_WIDTH(3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_load_mode    (load_mode),
        .in_fetch_req    (fetch_req),
        .in_fetch_addr   (fetch_addr),
        .out_fetch_gnt   (fetch_gnt),
        .out_fetch_rvalid(fetch_rvalid),
        .in_data_req     (data_req),
        .in_data_we      (data_we),
        .in_data_addr    (data_addr),
        .in_data_wdata   (data_wdata),
        .out_data_gnt    (data_gnt),
        .out_data_rvalid (data_rvalid),
        .in_load_req     (load_req),
        .in_load_addr    (load_addr),
        .in_load_wdata   (load_wdata),
        .out_load_gnt    (load_gnt),
        .out_load_busy   (load_busy),
        .out_rdata       (rdata),
        .out_pmem_addr   (pmem_addr),
        .out_pmem_wdata  (pmem_wdata),
        .out_pmem_we     (pmem_we),
        .in_pmem_rdata   (pmem_rdata)
    );

    // Behavioural memory: initial word at address a is 16'hA500 ^ a.
    logic [15:0] mem [0:4095];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'hA500 ^ 16'(i);
        end
        pmem_rdata = 16'h0000;
    end

    always @(posedge clock) begin
        pmem_rdata <= mem[pmem_addr];
        if (pmem_we) begin
            mem[pmem_addr] <= pmem_wdata;
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit          is_fetch;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_fetch, input logic [15:0] data);
        exp_t e;
        e.is_fetch = is_fetch;
        e.data     = data;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest expected read response.
    always @(negedge clock) begin
        if (reset === 1'b1 && (fetch_rvalid || data_rvalid)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got fetch_rvalid=%0b data_rvalid=%0b, expected no response (t=%0t)",
                         fetch_rvalid, data_rvalid, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rv_fetch", 32'(fetch_rvalid), 32'(e.is_fetch));
                check("rv_data", 32'(data_rvalid), 32'(!e.is_fetch));
                check("rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic check_gnts(input string tag, input bit f, input bit d, input bit l);
        check({tag, "_fetch_gnt"}, 32'(fetch_gnt), 32'(f));
        check({tag, "_data_gnt"}, 32'(data_gnt), 32'(d));
        check({tag, "_load_gnt"}, 32'(load_gnt), 32'(l));
    endtask

    initial begin
        reset      = 1'b0;
        load_mode  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 12'h000;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 12'h000;
        data_wdata = 16'h0000;
        load_req   = 1'b0;
        load_addr  = 12'h000;
        load_wdata = 16'h0000;

        // Reset state
        #3;
        check("rst_busy", 32'(load_busy), 0);
        check("rst_fetch_rvalid", 32'(fetch_rvalid), 0);
        check("rst_data_rvalid", 32'(data_rvalid), 0);
        check("rst_we", 32'(pmem_we), 0);
        check_gnts("rst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // 1: lone fetch
        fetch_req  = 1'b1;
        fetch_addr = 12'h010;
        @(negedge clock);
        check_gnts("t1", 1'b1, 1'b0, 1'b0);
        check("t1_addr", 32'(pmem_addr), 32'h010);
        check("t1_we", 32'(pmem_we), 0);
        push(1'b1, 16'hA510);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clock);
        check_gnts("idle", 1'b0, 1'b0, 1'b0);
        check("idle_we", 32'(pmem_we), 0);
        next_cycle();

        // 2: fetch and data read contend for six cycles
        fetch_req  = 1'b1;
        fetch_addr = 12'h011;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 12'h012;
        for (int k = 1; k <= 6; k++) begin
            bit exp_f;
            exp_f = GUARD && (k == 5);
            @(negedge clock);
            check_gnts("t2", exp_f, !exp_f, 1'b0);
            check("t2_addr", 32'(pmem_addr), exp_f ? 32'h011 : 32'h012);
            push(exp_f, exp_f ? 16'hA511 : 16'hA512);
            next_cycle();
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;

        // 3: data write then readback
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 12'h020;
        data_wdata = 16'hBEEF;
        @(negedge clock);
        check_gnts("t3w", 1'b0, 1'b1, 1'b0);
        check("t3w_we", 32'(pmem_we), 1);
        check("t3w_wdata", 32'(pmem_wdata), 32'hBEEF);
        check("t3w_addr", 32'(pmem_addr), 32'h020);
        next_cycle();
        data_we = 1'b0;
        @(negedge clock);
        check("t3_no_rvalid", 32'(data_rvalid), 0);
        check_gnts("t3r", 1'b0, 1'b1, 1'b0);
        check("t3r_we", 32'(pmem_we), 0);
        push(1'b0, 16'hBEEF);
        next_cycle();
        data_req = 1'b0;

        // 4: enter loader mode; read granted in last RUN cycle still returns
        load_mode  = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 12'h040;
        @(negedge clock);
        check_gnts("t4run", 1'b1, 1'b0, 1'b0);
        check("t4run_busy", 32'(load_busy), 0);
        push(1'b1, 16'hA540);
        next_cycle();
        fetch_addr = 12'h000;
        data_req   = 1'b1;
        data_addr  = 12'h030;
        load_req   = 1'b1;
        load_addr  = 12'h000;
        load_wdata = 16'h1234;
        @(negedge clock);
        check("t4_busy", 32'(load_busy), 1);
        check_gnts("t4load", 1'b0, 1'b0, 1'b1);
        check("t4_we", 32'(pmem_we), 1);
        check("t4_addr", 32'(pmem_addr), 32'h000);
        check("t4_wdata", 32'(pmem_wdata), 32'h1234);
        next_cycle();
        load_req = 1'b0;
        @(negedge clock);
        check_gnts("t4idle", 1'b0, 1'b0, 1'b0);
        check("t4idle_we", 32'(pmem_we), 0);
        next_cycle();
        load_mode = 1'b0;
        @(negedge clock);
        check_gnts("t4exit", 1'b0, 1'b0, 1'b0);
        check("t4exit_busy", 32'(load_busy), 1);
        next_cycle();
        data_req = 1'b0;
        @(negedge clock);
        check_gnts("t4rel", 1'b0, 1'b0, 1'b0);
        check("t4rel_busy", 32'(load_busy), 1);
        next_cycle();
        @(negedge clock);
        check("t4run2_busy", 32'(load_busy), 0);
        check_gnts("t4run2", 1'b1, 1'b0, 1'b0);
        check("t4run2_addr", 32'(pmem_addr), 32'h000);
        push(1'b1, 16'h1234);
        next_cycle();
        fetch_req = 1'b0;

        // 5: reset while in LOAD with a fetch response pending
        load_mode  = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 12'h050;
        @(negedge clock);
        check_gnts("t5run", 1'b1, 1'b0, 1'b0);
        next_cycle();
        fetch_req = 1'b0;
        check("t5_pending_rv", 32'(fetch_rvalid), 1);
        check("t5_pre_busy", 32'(load_busy), 1);
        #1 reset = 1'b0;
        #1;
        check("t5_busy", 32'(load_busy), 0);
        check("t5_fetch_rvalid", 32'(fetch_rvalid), 0);
        check("t5_data_rvalid", 32'(data_rvalid), 0);
        load_mode = 1'b0;
        next_cycle();
        reset = 1'b1;

        // 6: loader requests in RUN are ignored
        load_req   = 1'b1;
        load_addr  = 12'h060;
        load_wdata = 16'h5555;
        fetch_req  = 1'b1;
        fetch_addr = 12'h061;
        @(negedge clock);
        check_gnts("t6f", 1'b1, 1'b0, 1'b0);
        check("t6f_we", 32'(pmem_we), 0);
        check("t6f_addr", 32'(pmem_addr), 32'h061);
        push(1'b1, 16'hA561);
        next_cycle();
        fetch_req = 1'b0;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 12'h062;
        @(negedge clock);
        check_gnts("t6d", 1'b0, 1'b1, 1'b0);
        check("t6d_we", 32'(pmem_we), 0);
        check("t6d_addr", 32'(pmem_addr), 32'h062);
        check("t6d_busy", 32'(load_busy), 0);
        push(1'b0, 16'hA562);
        next_cycle();
        data_req = 1'b0;
        load_req = 1'b0;

        repeat (3) next_cycle();
        check("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
